// File: rtl/ether_gmii_rx.sv
`default_nettype none
// ============================================================================
// Module   : ether_gmii_rx
// Brief    : GMII receive front end. Strips preamble/SFD, checks and removes
//            the FCS, emits payload as a valid/sof/eof byte stream.
// Revision : 1.0  initial release
// ============================================================================
module ether_gmii_rx #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_dv,
    input  logic             rx_er,
    input  logic [7:0]       rx_data,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_good,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    localparam logic [31:0] c_poly     = 32'hEDB88320;
    localparam logic [31:0] c_residue  = 32'hDEBB20E3;
    localparam logic [10:0] c_min_len  = 11'(MIN_LEN);
    localparam logic [10:0] c_max_len  = 11'(MAX_LEN);
    localparam logic [10:0] c_len_sat  = 11'h7FF;
    localparam logic [10:0] c_dly_len  = 11'd5;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0][7:0] r_dly;
    logic [31:0]     r_crc;
    logic [10:0]     r_len;
    logic            r_err;

    logic w_emit, w_sof, w_eof, w_good, w_frame_inc, w_bad_inc, w_shift, w_start;
    logic w_len_ok;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_poly) : (c >> 1);
        end
        return c;
    endfunction

    assign w_len_ok = (r_len >= c_min_len) && (r_len <= c_max_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_sof       = 1'b0;
        w_eof       = 1'b0;
        w_good      = 1'b0;
        w_frame_inc = 1'b0;
        w_bad_inc   = 1'b0;
        w_shift     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_dv) w_state_nxt = (rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: begin
                if (!rx_dv) begin
                    w_state_nxt = S_IDLE;
                end else if (rx_data == 8'hD5) begin
                    w_state_nxt = S_PAYLOAD;
                    w_start     = 1'b1;
                end else if (rx_data != 8'h55) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_PAYLOAD: begin
                // The oldest delay-line byte leaves once five newer ones exist
                if (rx_dv) begin
                    w_shift = 1'b1;
                    if (r_len >= c_dly_len) begin
                        w_emit = 1'b1;
                        w_sof  = (r_len == c_dly_len);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    if (r_len >= c_dly_len) begin
                        w_emit      = 1'b1;
                        w_eof       = 1'b1;
                        w_sof       = (r_len == c_dly_len);
                        w_good      = (r_crc == c_residue) && !r_err && w_len_ok;
                        w_frame_inc = w_good;
                        w_bad_inc   = !w_good;
                    end else begin
                        w_bad_inc   = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (!rx_dv) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_good  <= 1'b0;
            frame_cnt <= '0;
            bad_cnt   <= '0;
            r_dly     <= '0;
            r_crc     <= 32'hFFFFFFFF;
            r_len     <= '0;
            r_err     <= 1'b0;
        end else begin
            out_valid <= w_emit;
            out_data  <= w_emit ? r_dly[4] : 8'h00;
            out_sof   <= w_sof;
            out_eof   <= w_eof;
            out_good  <= w_good;
            if (w_frame_inc && (frame_cnt != '1)) frame_cnt <= frame_cnt + CNT_W'(1);
            if (w_bad_inc && (bad_cnt != '1))     bad_cnt   <= bad_cnt + CNT_W'(1);
            if (w_start) begin
                r_crc <= 32'hFFFFFFFF;
                r_len <= '0;
                r_err <= 1'b0;
            end else if (w_shift) begin
                r_crc <= crc_byte(r_crc, rx_data);
                r_dly <= {r_dly[3:0], rx_data};
                if (r_len != c_len_sat) r_len <= r_len + 11'd1;
                if (rx_er)              r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ether_gmii_rx.md
Name: ether_gmii_rx

Overview:
GMII receive front end. It consumes the PHY receive bus (ETH_RX_CLK domain), strips the preamble and SFD, checks the FCS (CRC-32), and removes it from the stream. It then presents payload bytes as a valid/sof/eof byte stream with a per-frame good/bad status. It sits directly downstream of the PHY RX pins and upstream of all packet consumers; it is the receive counterpart of ether_sample_packet_tx.

Parameters:
MIN_LEN, 64, minimum frame length in bytes counted from the first post-SFD byte, FCS included
MAX_LEN, 1518, maximum frame length in bytes, same counting
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  receive clock (ETH_RX_CLK, 125 MHz)
rst_n  input  1  asynchronous active-low reset
rx_dv  input  1  GMII RX_DV
rx_er  input  1  GMII RX_ER
rx_data  input  8  GMII RXD
out_valid  output  1  out_data holds a payload byte this cycle
out_data  output  8  payload byte (destination MAC first, FCS excluded)
out_sof  output  1  first payload byte of the frame
out_eof  output  1  last payload byte of the frame
out_good  output  1  qualified by out_eof: FCS correct, no rx_er, length in [MIN_LEN, MAX_LEN]
frame_cnt  output  CNT_W  frames delivered with out_good=1, saturating
bad_cnt  output  CNT_W  frames delivered with out_good=0, plus runts of fewer than 5 bytes; saturating

Behaviour:
- Clock and reset are fixed: one clock, clk. rst_n is asynchronous and active-low.
- All outputs are registered. Every output resets to 0. The FSM resets to IDLE, and the delay line is cleared.
- rst_n asserted mid-frame aborts immediately: no eof is emitted and no counter changes. After release, the FSM sits in IDLE. If rx_dv is still high, it follows the IDLE rule for non-0x55 bytes and enters DROP.
- FSM states: IDLE, PREAMBLE, PAYLOAD, DROP.
  - IDLE: rx_dv=1 with data 0x55 -> PREAMBLE. rx_dv=1 with any other byte (including 0xD5) -> DROP.
  - PREAMBLE: 0x55 -> stay. 0xD5 -> PAYLOAD, and clear CRC, length and error state. Any other byte -> DROP. rx_dv=0 -> IDLE, silently.
  - PAYLOAD: every cycle with rx_dv=1 is a frame byte, index j = 0..N-1. rx_dv=0 ends the frame -> IDLE.
  - DROP: wait for rx_dv=0 -> IDLE. No output, no counter change.
- rx_er in PAYLOAD: latch the frame error flag, keep receiving, and force out_good=0. rx_er is ignored outside PAYLOAD.
- Delay line: 5-byte shift register, which hides the 4 FCS bytes.
  - For j <= N-6, byte j is output (out_valid=1) in the cycle after byte j+5 is sampled.
  - Byte N-5 is output with out_eof=1 in the cycle after rx_dv is first sampled 0.
  - out_sof accompanies byte 0. For N=5, byte 0 carries both out_sof and out_eof.
  - N<5: nothing is output and bad_cnt increments.
- CRC-32:
  - Polynomial 0x04C11DB7, reflected, processed LSB first, init 0xFFFFFFFF, one byte per cycle.
  - Runs over bytes 0..N-1, FCS included.
  - FCS is correct iff the register equals 0xDEBB20E3 after byte N-1.
- Length counter: 11 bits, saturates at 2047. Length is in range iff MIN_LEN <= N <= MAX_LEN.
- Status timing: out_good is valid only when out_eof=1 and is 0 otherwise. frame_cnt or bad_cnt updates on the same edge that drives out_eof.
- Counters saturate at all ones. They do not wrap.
- No backpressure: the consumer must accept one byte per cycle.
- Back-to-back frames: a new preamble may begin on the cycle after rx_dv falls. The eof emission for the previous frame happens in that same cycle and must not be corrupted.

Test Plan:
1. Set MIN_LEN=13. Drive 7x 0x55, 0xD5, ASCII "123456789", then FCS 0x26 0x39 0xF4 0xCB, then drop dv -> 9 bytes out, '1' with sof, '9' with eof, out_good=1, frame_cnt=1. The first out_valid occurs the cycle after the 6th post-SFD byte is sampled.
2. Repeat scenario 1 with the last FCS byte changed to 0xCA -> same 9 bytes out, out_good=0, bad_cnt=1.
3. Repeat scenario 1 with rx_er=1 for one cycle on byte '5' -> data unchanged, out_good=0.
4. Default parameters: a 60-byte payload with correct FCS (N=64) -> good. A 59-byte payload (N=63) -> out_good=0. N=1519 -> out_good=0.
5. Error paths:
   - Preamble of 0x55 then 0x5D then more bytes -> no output, counters unchanged.
   - SFD followed by only 3 bytes -> no output, bad_cnt+1.
6. Scenario 1 frame sent twice with one idle cycle between, then rst_n pulsed mid-payload of a third frame -> two good eofs, frame_cnt=2 until reset, then all outputs 0 and no eof for the aborted frame.
